// File: rtl/ycbcr422_to_444_pipe_if.sv
// ycbcr422_to_444_pipe_if: timing, luma and chroma bundle
// of the 4:2:2 to 4:4:4 upsampler.
interface ycbcr422_to_444_pipe_if #(
  parameter int DW = 8
);
  logic          i_v_sync;
  logic          i_h_sync;
  logic          i_de;
  logic [DW-1:0] y_in;
  logic [DW-1:0] c_in;
  logic          o_v_sync;
  logic          o_h_sync;
  logic          o_de;
  logic [DW-1:0] y_out;
  logic [DW-1:0] cb_out;
  logic [DW-1:0] cr_out;
  logic          o_odd_err;

  modport master (
    output i_v_sync, i_h_sync, i_de,
    output y_in, c_in,
    input  o_v_sync, o_h_sync, o_de,
    input  y_out, cb_out, cr_out,
    input  o_odd_err
  );

  modport slave (
    input  i_v_sync, i_h_sync, i_de,
    input  y_in, c_in,
    output o_v_sync, o_h_sync, o_de,
    output y_out, cb_out, cr_out,
    output o_odd_err
  );
endinterface

// File: rtl/ycbcr422_to_444_pipe.sv
// ycbcr422_to_444_pipe: 4:2:2 to 4:4:4 upsampler, 4 clk latency.
// Define CHROMA_INTERP_EN to average chroma on odd pixels.
module ycbcr422_to_444_pipe #(
  parameter int DW       = 8,
  parameter bit CB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  ycbcr422_to_444_pipe_if.slave bus
);

  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic          vs;
    logic          hs;
    logic          de;
    logic          ph;
    logic [DW-1:0] y;
    logic [DW-1:0] c;
  } smp_t;

  smp_t          s [4];
  logic          ph_nxt;
  logic          armed;
  logic [DW-1:0] pa;
  logic [DW-1:0] pb;
  logic          has_prev;
  logic          last_ph;
  logic [DW-1:0] a_v;
  logic [DW-1:0] b_v;

`ifdef CHROMA_INTERP_EN
  function automatic logic [DW-1:0] avg(
    input logic [DW-1:0] x,
    input logic [DW-1:0] y
  );
    return DW'(({1'b0, x} + {1'b0, y} + (DW+1)'(1)) >> 1);
  endfunction
`endif

  // armed blocks a line that was already running when reset dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) s[i] <= '0;
      ph_nxt <= 1'b0;
      armed  <= ~bus.i_de;
    end else begin
      s[0].vs <= bus.i_v_sync;
      s[0].hs <= bus.i_h_sync;
      s[0].de <= bus.i_de & armed;
      s[0].ph <= ph_nxt;
      if (bus.i_de) begin
        s[0].y <= bus.y_in;
        s[0].c <= bus.c_in;
      end
      for (int i = 1; i < 4; i++) s[i] <= s[i-1];
      ph_nxt <= bus.i_de & ~ph_nxt;
      if (!bus.i_de) armed <= 1'b1;
    end
  end

  // a = even-sample component, b = odd-sample component
  always_comb begin
    a_v = s[3].c;
    b_v = s[3].c;
    if (!s[3].ph) begin
      b_v = s[2].de ? s[2].c : (has_prev ? pb : MID);
    end else begin
      a_v = pa;
`ifdef CHROMA_INTERP_EN
      if (s[2].de) begin
        a_v = avg(pa, s[2].c);
        b_v = avg(s[3].c, s[1].de ? s[1].c : s[3].c);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_v_sync  <= 1'b0;
      bus.o_h_sync  <= 1'b0;
      bus.o_de      <= 1'b0;
      bus.o_odd_err <= 1'b0;
      bus.y_out     <= '0;
      bus.cb_out    <= '0;
      bus.cr_out    <= '0;
      pa            <= '0;
      pb            <= '0;
      has_prev      <= 1'b0;
      last_ph       <= 1'b0;
    end else begin
      bus.o_v_sync  <= s[3].vs;
      bus.o_h_sync  <= s[3].hs;
      bus.o_de      <= s[3].de;
      bus.o_odd_err <= ~s[3].de & bus.o_de & ~last_ph;
      if (s[3].de) begin
        bus.y_out  <= s[3].y;
        bus.cb_out <= CB_FIRST ? a_v : b_v;
        bus.cr_out <= CB_FIRST ? b_v : a_v;
        last_ph    <= s[3].ph;
        if (!s[3].ph) begin
          pa <= a_v;
          pb <= b_v;
        end else begin
          has_prev <= 1'b1;
        end
      end else begin
        bus.y_out  <= '0;
        bus.cb_out <= '0;
        bus.cr_out <= '0;
        has_prev   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ycbcr422_to_444_pipe.sv
// tb_ycbcr422_to_444_pipe: scoreboard bench, CB_FIRST=1 and
// CB_FIRST=0 instances driven with identical stimulus.
module tb_ycbcr422_to_444_pipe;

`ifdef CHROMA_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif
  localparam int NC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ec  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit eff_de [NC];
  bit in_vs  [NC];
  bit in_hs  [NC];
  bit rst_at [NC];

  typedef struct {
    int y;
    int cb;
    int cr;
  } pix_t;

  pix_t q1 [$];
  pix_t q0 [$];
  bit   odd_q [$];
  int   ly [$];
  int   lc [$];

  ycbcr422_to_444_pipe_if #(.DW(8)) bus1 ();
  ycbcr422_to_444_pipe_if #(.DW(8)) bus0 ();

  ycbcr422_to_444_pipe #(.DW(8), .CB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  ycbcr422_to_444_pipe #(.DW(8), .CB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d, want %0d", nm, ec, act, exp);
    end
  endtask

  task automatic drive(bit de, bit eff, int y, int c, bit r);
    int  n;
    bit  vs;
    bit  hs;
    n  = ec + 1;
    vs = 1'($urandom_range(0, 1));
    hs = 1'($urandom_range(0, 1));
    rst = r;
    bus1.i_de = de; bus0.i_de = de;
    bus1.i_v_sync = vs; bus0.i_v_sync = vs;
    bus1.i_h_sync = hs; bus0.i_h_sync = hs;
    bus1.y_in = 8'(y); bus0.y_in = 8'(y);
    bus1.c_in = 8'(c); bus0.c_in = 8'(c);
    if (n < NC) begin
      eff_de[n] = eff;
      in_vs[n]  = vs;
      in_hs[n]  = hs;
      rst_at[n] = r;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++)
      drive(1'b0, 1'b0, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 1'b0);
  endtask

  // reference: pair k = (A,B); a missing B borrows the previous
  // pair's B, or mid-scale for a 1-pixel line
  task automatic push_line();
    int   L;
    int   np;
    int   pa [$];
    int   pb [$];
    int   a;
    int   b;
    int   k;
    pix_t p;
    L  = ly.size();
    np = (L + 1) / 2;
    for (int j = 0; j < np; j++) begin
      pa.push_back(lc[2*j]);
      if (2*j + 1 < L) pb.push_back(lc[2*j+1]);
      else if (j > 0)  pb.push_back(pb[j-1]);
      else             pb.push_back(128);
    end
    for (int i = 0; i < L; i++) begin
      k = i / 2;
      a = pa[k];
      b = pb[k];
      if (INTERP && (i % 2 == 1) && (k + 1 < np)) begin
        a = (pa[k] + pa[k+1] + 1) / 2;
        b = (pb[k] + pb[k+1] + 1) / 2;
      end
      p.y = ly[i]; p.cb = a; p.cr = b;
      q1.push_back(p);
      p.cb = b; p.cr = a;
      q0.push_back(p);
    end
    odd_q.push_back(L % 2 == 1);
  endtask

  task automatic send_line(int gap);
    push_line();
    for (int i = 0; i < ly.size(); i++)
      drive(1'b1, 1'b1, ly[i], lc[i], 1'b0);
    idle(gap);
  endtask

  task automatic rand_line(int len, int gap);
    ly.delete(); lc.delete();
    for (int i = 0; i < len; i++) begin
      ly.push_back(int'($urandom_range(0, 255)));
      lc.push_back(int'($urandom_range(0, 255)));
    end
    send_line(gap);
  endtask

  // reset hits on the 2nd pixel; the rest of that line must be ignored
  task automatic reset_line(int len, int gap);
    drive(1'b1, 1'b0, 77, 99, 1'b0);
    drive(1'b1, 1'b0, 78, 98, 1'b1);
    for (int i = 2; i < len; i++)
      drive(1'b1, 1'b0, 79 + i, 97 - i, 1'b0);
    idle(gap);
  endtask

  // monitor
  initial begin
    int   m;
    bit   killed;
    bit   exp_de;
    bit   exp_vs;
    bit   exp_hs;
    bit   prev_de;
    bit   exp_odd;
    pix_t e1;
    pix_t e0;
    prev_de = 1'b0;
    forever begin
      @(negedge clk);
      m = ec;
      killed = 1'b0;
      for (int j = m - 4; j <= m; j++)
        if (j >= 0 && j < NC && rst_at[j]) killed = 1'b1;
      exp_de = 1'b0; exp_vs = 1'b0; exp_hs = 1'b0;
      if (!killed && m > 4 && m - 4 < NC) begin
        exp_de = eff_de[m-4];
        exp_vs = in_vs[m-4];
        exp_hs = in_hs[m-4];
      end
      chk("de1", 32'(bus1.o_de), 32'(exp_de));
      chk("de0", 32'(bus0.o_de), 32'(exp_de));
      chk("vs1", 32'(bus1.o_v_sync), 32'(exp_vs));
      chk("hs1", 32'(bus1.o_h_sync), 32'(exp_hs));
      chk("vs0", 32'(bus0.o_v_sync), 32'(exp_vs));
      chk("hs0", 32'(bus0.o_h_sync), 32'(exp_hs));
      exp_odd = 1'b0;
      if (prev_de && !exp_de && !killed) begin
        if (odd_q.size() == 0) chk("odd_q_underflow", 1, 0);
        else exp_odd = odd_q.pop_front();
      end
      chk("odd1", 32'(bus1.o_odd_err), 32'(exp_odd));
      chk("odd0", 32'(bus0.o_odd_err), 32'(exp_odd));
      prev_de = exp_de;
      if (bus1.o_de === 1'b1) begin
        if (q1.size() == 0) chk("q1_underflow", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("y1", 32'(bus1.y_out), 32'(e1.y));
          chk("cb1", 32'(bus1.cb_out), 32'(e1.cb));
          chk("cr1", 32'(bus1.cr_out), 32'(e1.cr));
        end
      end else begin
        chk("blank1", {8'd0, bus1.y_out, bus1.cb_out, bus1.cr_out}, 0);
      end
      if (bus0.o_de === 1'b1) begin
        if (q0.size() == 0) chk("q0_underflow", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("y0", 32'(bus0.y_out), 32'(e0.y));
          chk("cb0", 32'(bus0.cb_out), 32'(e0.cb));
          chk("cr0", 32'(bus0.cr_out), 32'(e0.cr));
        end
      end else begin
        chk("blank0", {8'd0, bus0.y_out, bus0.cb_out, bus0.cr_out}, 0);
      end
    end
  end

  // stimulus
  initial begin
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 0, 1'b1);
    idle(2);
    ly = '{1, 2, 3, 4};   lc = '{10, 20, 30, 40};
    send_line(6);
    ly = '{1, 2};         lc = '{20, 10};
    send_line(6);
    ly = '{1, 2, 3};      lc = '{10, 20, 30};
    send_line(6);
    ly = '{5};            lc = '{10};
    send_line(6);
    reset_line(6, 3);
    rand_line(4, 6);
    rand_line(5, 2);
    rand_line(6, 6);
    rand_line(3, 1);
    rand_line(1, 1);
    rand_line(2, 4);
    for (int i = 0; i < 40; i++)
      rand_line(int'($urandom_range(1, 16)), int'($urandom_range(1, 6)));
    idle(10);
    chk("q1_left", 32'(q1.size()), 0);
    chk("q0_left", 32'(q0.size()), 0);
    chk("odd_left", 32'(odd_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
